// File: rtl/tick_scheduler.sv
// Four-channel programmable tick generator: each channel emits a one-cycle pulse
// every div+1 cycles; a two-state handshake FSM writes one channel's config at a time.

module tick_scheduler_ch #(
   parameter int CNT_W = 25
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic             en_i,
   input  logic             sync_i,
   output logic             tick_o,
   output logic             active_o
);
   logic [CNT_W-1:0] div_q, cnt_q, cnt_d;
   logic             en_q, tick_q, tick_d, hit;

   assign hit = en_q && (cnt_q == div_q);

   // Any restart (write, phase-align, disabled) zeroes the counter and kills the pending tick.
   always_comb begin
      cnt_d  = hit ? '0 : cnt_q + CNT_W'(1);
      tick_d = hit;
      if (wr_i || sync_i || !en_q) begin
         cnt_d  = '0;
         tick_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         div_q  <= '0;
         en_q   <= 1'b0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         if (wr_i) begin
            div_q <= div_i;
            en_q  <= en_i;
         end
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o   = tick_q;
   assign active_o = en_q;
endmodule

module tick_scheduler #(
   parameter int CNT_W  = 25,
   parameter int NUM_CH = 4
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_en,
   input  logic              sync_all,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] active
);
   typedef enum logic {IDLE, APPLY} state_t;

   state_t           state_q;
   logic             ready_q;
   logic [1:0]       ch_q;
   logic [CNT_W-1:0] div_q;
   logic             en_q;
   logic             accept;
   logic [NUM_CH-1:0] wr;

   assign accept = (state_q == IDLE) && cfg_valid && ready_q;

   // ready_q stays low for the first cycle out of reset, then tracks IDLE.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         ch_q    <= '0;
         div_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  ch_q    <= cfg_ch;
                  div_q   <= cfg_div;
                  en_q    <= cfg_en;
                  state_q <= APPLY;
                  ready_q <= 1'b0;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            APPLY: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = ready_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign wr[g] = (state_q == APPLY) && (ch_q == 2'(g));

      tick_scheduler_ch #(.CNT_W(CNT_W)) u_ch (
         .clk_in   (clk_in),
         .rst      (rst),
         .wr_i     (wr[g]),
         .div_i    (div_q),
         .en_i     (en_q),
         .sync_i   (sync_all),
         .tick_o   (tick[g]),
         .active_o (active[g])
      );
   end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: constant vector table, directed corner sequences and a
// randomized run against a period/phase model (tick when (edge - restart) % (div+1) == 0).

module tb_tick_scheduler;
   logic        clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic        rst = 1'b1, cfg_valid = 1'b0, cfg_en = 1'b0, sync_all = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [24:0] cfg_div = '0;
   logic        cfg_ready;
   logic [3:0]  tick, active;

   logic        rst2 = 1'b1, v2 = 1'b0, en2 = 1'b0, sync2 = 1'b0;
   logic [1:0]  ch2 = '0;
   logic [3:0]  div2 = '0;
   logic        ready2;
   logic [3:0]  tick2, active2;

   tick_scheduler dut (
      .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .sync_all(sync_all),
      .tick(tick), .active(active));

   tick_scheduler #(.CNT_W(4)) dut4 (
      .clk_in(clk_in), .rst(rst2), .cfg_valid(v2), .cfg_ready(ready2),
      .cfg_ch(ch2), .cfg_div(div2), .cfg_en(en2), .sync_all(sync2),
      .tick(tick2), .active(active2));

   // Reference: per channel, enable, divisor and the edge index of its last restart.
   int e = 0;
   int m_en[4], m_div[4], m_t0[4];
   bit m_ready = 1'b0, m_pend = 1'b0, m_pen = 1'b0;
   int m_pch = 0, m_pdiv = 0;
   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
      end
   endtask

   function automatic logic [8:0] model_out();
      logic [3:0] tk, ac;
      tk = '0;
      ac = '0;
      for (int i = 0; i < 4; i++) begin
         ac[i] = (m_en[i] != 0);
         tk[i] = (m_en[i] != 0) && (e > m_t0[i]) && (((e - m_t0[i]) % (m_div[i] + 1)) == 0);
      end
      return {m_ready, tk, ac};
   endfunction

   task automatic cycle();
      @(posedge clk_in);
      e++;
      if (rst) begin
         m_ready = 1'b0;
         m_pend  = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_en[i] = 0; m_div[i] = 0; m_t0[i] = e;
         end
      end else begin
         if (m_pend) begin
            m_en[m_pch]  = int'(m_pen);
            m_div[m_pch] = m_pdiv;
            m_t0[m_pch]  = e;
            m_pend  = 1'b0;
            m_ready = 1'b1;
         end else if (cfg_valid && m_ready) begin
            m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div); m_pen = cfg_en;
            m_pend  = 1'b1;
            m_ready = 1'b0;
         end else begin
            m_ready = 1'b1;
         end
         if (sync_all) for (int i = 0; i < 4; i++) m_t0[i] = e;
      end
      #1;
      check("model", 32'({cfg_ready, tick, active}), 32'(model_out()));
   endtask

   task automatic configure(input int ch, input int div, input bit en);
      int w;
      cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 25'(div); cfg_en = en;
      w = 0;
      while (!cfg_ready && w < 10) begin cycle(); w++; end
      check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
      cycle();
      cfg_valid = 1'b0;
      cycle();
   endtask

   typedef struct {
      logic rst, v; logic [1:0] ch; logic [24:0] div; logic en, sync;
      logic rdy; logic [3:0] tk, ac;
   } vec_t;
   vec_t tbl[13];

   initial begin
      int c0, c1, c2, k1, k2, w;
      logic [3:0] rp, sp;
      for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_div[i] = 0; m_t0[i] = 0; end

      tbl[0]  = '{1'b1,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b0,4'h0,4'h0};
      tbl[1]  = '{1'b1,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b0,4'h0,4'h0};
      tbl[2]  = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h0};
      tbl[3]  = '{1'b0,1'b1,2'd0,25'd3,1'b1,1'b0, 1'b0,4'h0,4'h0};
      tbl[4]  = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h1};
      tbl[5]  = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h1};
      tbl[6]  = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h1};
      tbl[7]  = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h1};
      tbl[8]  = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h1,4'h1};
      tbl[9]  = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h1};
      tbl[10] = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h1};
      tbl[11] = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h0,4'h1};
      tbl[12] = '{1'b0,1'b0,2'd0,25'd0,1'b0,1'b0, 1'b1,4'h1,4'h1};

      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst; cfg_valid = tbl[i].v; cfg_ch = tbl[i].ch;
         cfg_div = tbl[i].div; cfg_en = tbl[i].en; sync_all = tbl[i].sync;
         cycle();
         check($sformatf("vec%0d", i), 32'({cfg_ready, tick, active}),
               32'({tbl[i].rdy, tbl[i].tk, tbl[i].ac}));
      end

      // Back-to-back writes with cfg_valid held high.
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 25'd0; cfg_en = 1'b1;
      cycle(); rp[3] = cfg_ready;
      cfg_ch = 2'd2; cfg_div = 25'd9;
      cycle(); rp[2] = cfg_ready;
      cycle(); rp[1] = cfg_ready;
      cfg_valid = 1'b0;
      cycle(); rp[0] = cfg_ready;
      check("ready_toggle", 32'(rp), 32'b0101);
      c0 = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(); c0 += int'(tick[0]); c1 += int'(tick[1]); c2 += int'(tick[2]);
      end
      check("ch1_every_cycle", 32'(c1), 32'd20);
      check("ch2_period10", 32'(c2), 32'd2);
      check("ch0_undisturbed", 32'(c0), 32'd5);

      // sync_all landing on ch0 counter==3.
      w = 0;
      do begin cycle(); w++; end while (!tick[0] && w < 10);
      check("ch0_tick_seen", 32'(tick[0]), 32'd1);
      cycle(); cycle(); cycle();
      sync_all = 1'b1;
      cycle();
      sync_all = 1'b0;
      check("sync_suppress", 32'(tick), 32'd0);
      for (int i = 0; i < 4; i++) begin cycle(); sp = {sp[2:0], tick[0]}; end
      check("sync_next_tick", 32'(sp), 32'b0001);
      check("sync_aligned", 32'(tick), 32'b0011);

      // Disable ch2, then re-enable at period 2.
      configure(2, 7, 1'b0);
      c2 = 0;
      for (int i = 0; i < 12; i++) begin cycle(); c2 += int'(tick[2]); end
      check("ch2_disabled_ticks", 32'(c2), 32'd0);
      check("ch2_inactive", 32'(active[2]), 32'd0);
      configure(2, 1, 1'b1);
      c2 = 0;
      for (int i = 0; i < 10; i++) begin cycle(); c2 += int'(tick[2]); end
      check("ch2_period2", 32'(c2), 32'd5);

      // Reset landing on the APPLY cycle.
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 25'd2; cfg_en = 1'b1;
      cycle();
      cfg_valid = 1'b0; rst = 1'b1;
      cycle();
      check("rst_in_apply", 32'({cfg_ready, tick, active}), 32'd0);
      cycle();
      rst = 1'b0;
      cycle();
      check("rst_release", 32'({cfg_ready, tick, active}), 32'h100);
      c0 = 0;
      for (int i = 0; i < 10; i++) begin cycle(); c0 += int'(|tick); end
      check("no_ticks_after_rst", 32'(c0), 32'd0);
      check("ch3_not_written", 32'(active), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         cfg_valid = ($urandom_range(0, 9) < 3);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_div   = 25'($urandom_range(0, 12));
         cfg_en    = ($urandom_range(0, 4) != 0);
         sync_all  = ($urandom_range(0, 39) == 0);
         cycle();
      end
      rst = 1'b0; cfg_valid = 1'b0; sync_all = 1'b0;

      // Narrow counter, all-ones divisor.
      rst2 = 1'b0;
      cycle();
      check("w4_ready", 32'(ready2), 32'd1);
      v2 = 1'b1; ch2 = 2'd0; div2 = 4'd15; en2 = 1'b1;
      cycle();
      v2 = 1'b0;
      cycle();
      k1 = -1; k2 = -1; c0 = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         if (tick2[0]) begin
            c0++;
            if (k1 < 0) k1 = i; else if (k2 < 0) k2 = i;
         end
      end
      check("w4_first_tick", 32'(k1), 32'd16);
      check("w4_period", 32'(k2 - k1), 32'd16);
      check("w4_count", 32'(c0), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter CNT_W, default 25, SHALL set the width of every divisor and channel counter.
REQ-002 Parameter NUM_CH, default 4, SHALL set the channel count; it is fixed at 4 in this revision.
REQ-003 clk_in  input  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 cfg_valid  input  1  SHALL flag a configuration request.
REQ-006 cfg_ready  output  1  SHALL indicate the block can accept a configuration request.
REQ-007 cfg_ch  input  2  SHALL select the target channel.
REQ-008 cfg_div  input  CNT_W  SHALL carry the terminal count; the period is cfg_div+1 cycles.
REQ-009 cfg_en  input  1  SHALL carry the enable value for the target channel.
REQ-010 sync_all  input  1  SHALL request a phase-align of all channel counters.
REQ-011 tick  output  4  SHALL carry the per-channel one-cycle enable pulses.
REQ-012 active  output  4  SHALL carry the per-channel enable status.

Function
REQ-013 Per channel, the block SHALL hold: div register (CNT_W), en flag, counter (CNT_W).
REQ-014 Enabled channel: the counter SHALL increment by 1 each cycle and wrap to 0 in the cycle after counter==div.
REQ-015 tick[ch] SHALL be registered and SHALL be high for exactly the one cycle after the counter equals div (i.e. one tick per div+1 cycles).
REQ-016 div==0 with the channel enabled: tick[ch] SHALL be high every cycle.
REQ-017 div==all-ones: the counter SHALL wrap without overflow, giving a 2^CNT_W cycle period.
REQ-018 Disabled channel: the counter SHALL be held at 0 and tick[ch] SHALL be 0.
REQ-019 Configuration FSM states SHALL be IDLE and APPLY.
REQ-020 In IDLE, cfg_ready SHALL be 1.
REQ-021 IDLE with cfg_valid && cfg_ready: the block SHALL capture cfg_ch, cfg_div and cfg_en into holding registers and go to APPLY.
REQ-022 In APPLY, cfg_ready SHALL be 0.
REQ-023 In APPLY, the block SHALL write div[ch] and en[ch], clear counter[ch] to 0, and return to IDLE; the minimum accept spacing is 2 cycles.
REQ-024 cfg_valid while cfg_ready==0 SHALL be ignored; the requester SHALL hold cfg_valid until accepted.
REQ-025 The new divisor SHALL take effect with its first full period: the first tick occurs div+1 cycles after the APPLY cycle.
REQ-026 active[ch] SHALL equal en[ch] and SHALL update in the cycle after APPLY.
REQ-027 Channels not targeted by APPLY SHALL continue counting undisturbed.
REQ-028 sync_all high SHALL clear every counter to 0 on that edge and SHALL suppress all ticks in the following cycle.
REQ-029 sync_all coincident with APPLY: the configuration write SHALL complete and all counters SHALL clear, including the targeted channel.
REQ-030 A counter reaching div on the same edge as sync_all SHALL produce no tick; the clear SHALL take priority.
REQ-031 Reconfiguring a channel to a div below its current counter value SHALL be safe, because APPLY clears that counter.

Reset
REQ-032 rst SHALL take priority over all other inputs.
REQ-033 While rst is high, FSM=IDLE, all counters=0, all div=0, all en=0, tick=0, active=0 and cfg_ready=0.
REQ-034 cfg_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-035 rst during APPLY SHALL discard the pending write.

Verification
REQ-036 Reset, then configure ch0 with div=3, en=1 -> tick[0] pulses every 4 cycles, first pulse 4 cycles after APPLY; active=0001.
REQ-037 Configure ch1 div=0 en=1 and ch2 div=9 en=1 back-to-back with cfg_valid held high -> cfg_ready toggles 1,0,1,0; tick[1] is high every cycle; tick[2] has period 10; ch0 phase is unchanged.
REQ-038 ch0 running with div=3, assert sync_all at counter==3 -> no tick that cycle; next tick[0] 4 cycles later; all channels are phase-aligned.
REQ-039 Write ch2 with en=0 -> tick[2] stays 0 and active[2]=0; rewrite with div=1 en=1 -> tick[2] period 2.
REQ-040 Assert rst mid-APPLY with channels running -> all outputs 0 and the pending write is not applied; after deassert, cfg_ready=1 and no ticks occur until reconfigured.
REQ-041 Set CNT_W=4 with div=15 -> tick period 16 and the counter wraps cleanly from 15 to 0.
